// File: rtl/mips_pkg.sv
// Shared encodings and sizing for the multiply/divide unit.
package mips_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MD_CYCLES = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Per-operation context captured when an arithmetic op is accepted.
    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic sign_q;
        logic sign_r;
        logic divzero;
    } md_ctx_t;

endpackage

// File: rtl/mdu_core.sv
// Shift-add multiply / restoring divide datapath: one 33-bit add/subtract step per cycle.
module mdu_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             div_q;

    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   sum;
    logic             cout;
    logic [WIDTH-1:0] p_n;
    logic [WIDTH-1:0] q_n;

    // Shared adder: P + (Q[0] ? M : 0) for multiply, shifted R - M for divide (carry = no borrow).
    always_comb begin
        sh    = {p, q[WIDTH-1]};
        add_a = div_q ? sh : {1'b0, p};
        add_b = div_q ? ~{1'b0, m} : {1'b0, (q[0] ? m : '0)};
        {cout, sum} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, div_q};
        if (div_q) begin
            p_n = cout ? sum[WIDTH-1:0] : sh[WIDTH-1:0];
            q_n = {q[WIDTH-2:0], cout};
        end else begin
            p_n = sum[WIDTH:1];
            q_n = {sum[0], q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p     <= '0;
            q     <= '0;
            m     <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            p     <= '0;
            q     <= is_div ? a_mag : b_mag;
            m     <= is_div ? b_mag : a_mag;
            div_q <= is_div;
        end else if (step) begin
            p <= p_n;
            q <= q_n;
        end
    end

    assign acc_hi = p;
    assign acc_lo = q;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/DIV unit with HI/LO: FSM, sign handling and architectural registers.
module mdu_hilo
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             start,
    input  logic [2:0]       mdop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    md_ctx_t          ctx, ctx_d;
    logic [WIDTH-1:0] raw1, raw1_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d;

    logic             load, step, in_div, in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (in_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    // Operand magnitudes and sign fix-up of the raw engine result.
    always_comb begin
        in_signed = (mdop == MD_MULT) || (mdop == MD_DIV);
        in_div    = (mdop == MD_DIV)  || (mdop == MD_DIVU);
        a_mag     = (in_signed && op1[WIDTH-1]) ? -op1 : op1;
        b_mag     = (in_signed && op2[WIDTH-1]) ? -op2 : op2;
        prod      = {acc_hi, acc_lo};
        quo       = acc_lo;
        rem       = acc_hi;
        if (ctx.is_signed && ctx.sign_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (ctx.is_signed && ctx.sign_r) begin
            rem = -rem;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ctx_d   = ctx;
        raw1_d  = raw1;
        hi_d    = hi;
        lo_d    = lo;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (mdop)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            load            = 1'b1;
                            cnt_d           = '0;
                            ctx_d.is_div    = in_div;
                            ctx_d.is_signed = in_signed;
                            ctx_d.sign_q    = in_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                            ctx_d.sign_r    = in_signed & op1[WIDTH-1];
                            ctx_d.divzero   = (op2 == '0);
                            raw1_d          = op1;
                            state_d         = ST_CALC;
                        end
                        MD_MTHI: hi_d = op1;
                        MD_MTLO: lo_d = op1;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(MD_CYCLES - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!ctx.is_div) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (ctx.divzero) begin
                    hi_d = raw1;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ctx   <= '0;
            raw1  <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ctx   <= ctx_d;
            raw1  <= raw1_d;
            hi    <= hi_d;
            lo    <= lo_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule
